// File: rtl/spi_cfg_controller_pkg.sv
// Shared definitions for the SPI configuration controller: FSM states,
// frame layout and the PWM configuration register map.
package spi_cfg_controller_pkg;

    localparam int RW_W    = 1;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;
    localparam int FRAME_W = RW_W + ADDR_W + DATA_W;

    localparam logic [4:0] FRAME_BITS = 5'd16;
    localparam int         NUM_REGS   = 5;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY  = 7'h04;

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } frame_t;

endpackage

// File: rtl/spi_cfg_controller_sync_edge.sv
// Synchronizer chain plus edge detector for one asynchronous SPI input.
// Edges are taken from the last two synchronized samples only.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++)
                chain[i] <= chain[i-1];
            prev <= chain[SYNC_STAGES-1];
        end
    end

    assign sync = chain[SYNC_STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/spi_cfg_controller.sv
// SPI write-only configuration port: captures 16-bit frames and commits
// valid writes into the five PWM configuration registers.
module spi_cfg_controller
    import spi_cfg_controller_pkg::*;
#(
    parameter int                SYNC_STAGES = 2,
    parameter logic [ADDR_W-1:0] MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       frame_done,
    output logic       frame_err
);

    logic sclk_sync, sclk_rise, sclk_fall;
    logic copi_sync, copi_rise, copi_fall;
    logic ncs_sync, ncs_rise, ncs_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
        .clk(clk), .rst(rst), .din(sclk), .sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_copi (
        .clk(clk), .rst(rst), .din(copi), .sync(copi_sync), .rise(copi_rise), .fall(copi_fall));
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ncs (
        .clk(clk), .rst(rst), .din(ncs), .sync(ncs_sync), .rise(ncs_rise), .fall(ncs_fall));

    logic unused_edges;
    assign unused_edges = &{1'b0, sclk_sync, sclk_fall, copi_rise, copi_fall};

    logic [1:0]                    state;
    logic [FRAME_W-1:0]            shreg;
    logic [4:0]                    cnt;
    logic                          ovr;
    logic [NUM_REGS-1:0][DATA_W-1:0] cfg_regs;
    frame_t                        frm;
    logic                          wr_hit;

    assign frm = frame_t'(shreg);
    // Both bounds matter: MAX_ADDR may be overridden past the physical map.
    assign wr_hit = frm.rw && (frm.addr <= MAX_ADDR) && (frm.addr <= ADDR_PWM_DUTY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            cnt        <= '0;
            ovr        <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            cfg_regs   <= '0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ncs_fall) begin
                        shreg <= '0;
                        cnt   <= '0;
                        ovr   <= 1'b0;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // ncs rise wins over a coincident sclk rise
                    if (ncs_rise) begin
                        if (cnt == FRAME_BITS && !ovr) begin
                            state <= ST_COMMIT;
                        end else begin
                            state     <= ST_IDLE;
                            frame_err <= 1'b1;
                        end
                    end else if (sclk_rise && !ncs_sync) begin
                        if (cnt == FRAME_BITS) begin
                            ovr <= 1'b1;
                        end else begin
                            shreg <= {shreg[FRAME_W-2:0], copi_sync};
                            cnt   <= cnt + 5'd1;
                        end
                    end
                end
                ST_COMMIT: begin
                    if (wr_hit)
                        cfg_regs[frm.addr[2:0]] <= frm.data;
                    frame_done <= 1'b1;
                    if (ncs_fall) begin
                        shreg <= '0;
                        cnt   <= '0;
                        ovr   <= 1'b0;
                        state <= ST_SHIFT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign en_reg_out_7_0  = cfg_regs[ADDR_EN_OUT_LO[2:0]];
    assign en_reg_out_15_8 = cfg_regs[ADDR_EN_OUT_HI[2:0]];
    assign en_reg_pwm_7_0  = cfg_regs[ADDR_EN_PWM_LO[2:0]];
    assign en_reg_pwm_15_8 = cfg_regs[ADDR_EN_PWM_HI[2:0]];
    assign pwm_duty_cycle  = cfg_regs[ADDR_PWM_DUTY[2:0]];

endmodule

// File: tb/tb_spi_cfg_controller.sv
// Directed bench for spi_cfg_controller: frames are bit-banged on sclk/copi/ncs
// and outputs compared against hand-computed values.
module tb_spi_cfg_controller;

    localparam int SYNC = 2;
    localparam int HALF = 4;

    logic       clk = 1'b0;
    logic       rst, sclk, copi, ncs;
    logic [7:0] out_lo, out_hi, pwm_lo, pwm_hi, duty;
    logic       frame_done, frame_err;

    int errors = 0;
    int checks = 0;
    int done_total = 0;
    int err_total = 0;
    int both_total = 0;
    int d0, e0;

    always #5 clk = ~clk;

    spi_cfg_controller #(.SYNC_STAGES(SYNC), .MAX_ADDR(7'h04)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
        .en_reg_out_7_0(out_lo), .en_reg_out_15_8(out_hi),
        .en_reg_pwm_7_0(pwm_lo), .en_reg_pwm_15_8(pwm_hi),
        .pwm_duty_cycle(duty), .frame_done(frame_done), .frame_err(frame_err));

    always @(negedge clk) begin
        if (frame_done) done_total++;
        if (frame_err) err_total++;
        if (frame_done && frame_err) both_total++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [31:0] bits, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            copi = bits[i];
            wait_clk(HALF);
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
    endtask

    // Leaves ncs freshly raised on return so callers can time the commit.
    task automatic send_frame(input logic [31:0] bits, input int nbits);
        ncs = 1'b0;
        wait_clk(HALF);
        spi_bits(bits, nbits);
        wait_clk(HALF);
        ncs = 1'b1;
    endtask

    task automatic snap();
        d0 = done_total;
        e0 = err_total;
    endtask

    initial begin
        rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
        wait_clk(3);
        chk("rst_out_lo", {24'd0, out_lo}, 32'h00);
        chk("rst_out_hi", {24'd0, out_hi}, 32'h00);
        chk("rst_pwm_lo", {24'd0, pwm_lo}, 32'h00);
        chk("rst_pwm_hi", {24'd0, pwm_hi}, 32'h00);
        chk("rst_duty", {24'd0, duty}, 32'h00);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        chk("rst_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        wait_clk(6);

        // write 0xF0 to address 0x00
        snap();
        send_frame(32'h80F0, 16);
        wait_clk(12);
        chk("w00_val", {24'd0, out_lo}, 32'hF0);
        chk("w00_done", done_total - d0, 1);
        chk("w00_err", err_total - e0, 0);
        chk("w00_others", {out_hi, pwm_lo, pwm_hi, duty}, 32'h0);

        // duty write, visibility exactly 2 cycles after the synced ncs rise
        snap();
        send_frame(32'h8480, 16);
        wait_clk(SYNC + 1);
        chk("w04_early", {24'd0, duty}, 32'h00);
        chk("w04_early_done", {31'd0, frame_done}, 32'd0);
        wait_clk(1);
        chk("w04_val", {24'd0, duty}, 32'h80);
        chk("w04_done_pulse", {31'd0, frame_done}, 32'd1);
        wait_clk(1);
        chk("w04_done_gone", {31'd0, frame_done}, 32'd0);
        wait_clk(10);
        chk("w04_done_cnt", done_total - d0, 1);

        // out-of-range write and a read: done pulses, no register change
        snap();
        send_frame(32'hB0AA, 16);
        wait_clk(12);
        send_frame(32'h0055, 16);
        wait_clk(12);
        chk("nowr_done", done_total - d0, 2);
        chk("nowr_err", err_total - e0, 0);
        chk("nowr_regs", {out_lo, out_hi, pwm_lo, pwm_hi}, 32'hF0000000);
        chk("nowr_duty", {24'd0, duty}, 32'h80);

        // 15-bit and 17-bit frames targeting 0x01 with 0xFF
        snap();
        send_frame(32'h40FF, 15);
        wait_clk(12);
        chk("short_err", err_total - e0, 1);
        send_frame(32'h103FE, 17);
        wait_clk(12);
        chk("long_err", err_total - e0, 2);
        chk("bad_done", done_total - d0, 0);
        chk("bad_out_hi", {24'd0, out_hi}, 32'h00);

        // back-to-back frames with minimum ncs high gap
        snap();
        send_frame(32'h8211, 16);
        wait_clk(SYNC + 1);
        send_frame(32'h8222, 16);
        wait_clk(12);
        chk("b2b_pwm_lo", {24'd0, pwm_lo}, 32'h22);
        chk("b2b_done", done_total - d0, 2);
        chk("b2b_err", err_total - e0, 0);

        // reset mid-frame, then a fresh frame
        snap();
        ncs = 1'b0;
        wait_clk(HALF);
        spi_bits(32'h83, 8);
        rst = 1'b1;
        wait_clk(3);
        chk("mid_rst_pwm_lo", {24'd0, pwm_lo}, 32'h00);
        rst = 1'b0;
        spi_bits(32'hFF, 8);
        wait_clk(HALF);
        ncs = 1'b1;
        wait_clk(12);
        chk("abort_pwm_hi", {24'd0, pwm_hi}, 32'h00);
        chk("abort_done", done_total - d0, 0);
        chk("abort_err", err_total - e0, 0);
        send_frame(32'h8301, 16);
        wait_clk(12);
        chk("post_rst_pwm_hi", {24'd0, pwm_hi}, 32'h01);
        chk("post_rst_done", done_total - d0, 1);
        chk("post_rst_out_lo", {24'd0, out_lo}, 32'h00);

        chk("never_both", both_total, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_cfg_controller.md
SPI_CFG_CONTROLLER -- requirements
Module: spi_cfg_controller

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth applied to each SPI input.
REQ-002 SHALL have parameter MAX_ADDR, default 7'h04, giving the highest writable register address.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port sclk, input, 1 bit: SPI clock, asynchronous to clk.
REQ-006 SHALL have port copi, input, 1 bit: SPI serial data in, sampled on the sclk rising edge, MSB first.
REQ-007 SHALL have port ncs, input, 1 bit: SPI chip select, active-low, framing one transaction.
REQ-008 SHALL have ports en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8 and pwm_duty_cycle, each an 8-bit output: the PWM peripheral configuration registers at addresses 0x00 to 0x04 respectively.
REQ-009 SHALL have port frame_done, output, 1 bit: one-cycle pulse marking a committed valid frame.
REQ-010 SHALL have port frame_err, output, 1 bit: one-cycle pulse marking a discarded malformed frame.

Function
REQ-011 SHALL pass sclk, copi and ncs through SYNC_STAGES flops each, and SHALL detect edges only on the synchronized signals, using the last two synchronized samples.
REQ-012 SHALL treat a frame as 16 bits: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
REQ-013 SHALL implement a state machine with states IDLE, SHIFT and COMMIT.
REQ-014 IDLE: on a synchronized ncs falling edge, SHALL clear the shift register, bit count and overrun flag, then go to SHIFT.
REQ-015 SHIFT, on each synchronized sclk rising edge while ncs is low: SHALL shift in copi and increment the bit count, saturating at 16.
REQ-016 SHIFT: an sclk rising edge arriving when the count is already 16 SHALL set the overrun flag.
REQ-017 SHIFT: on a synchronized ncs rising edge, SHALL go to COMMIT if the count is 16 and there is no overrun.
REQ-018 SHIFT: on a synchronized ncs rising edge with a count other than 16 or with overrun, SHALL return to IDLE, pulse frame_err and leave every register unchanged.
REQ-019 COMMIT: if bit15 = 1 and the address is at most MAX_ADDR, SHALL write the data byte to the addressed register.
REQ-020 COMMIT: SHALL pulse frame_done for exactly one cycle, including for read frames and out-of-range addresses, which write nothing and do not pulse frame_err.
REQ-021 COMMIT SHALL last exactly one cycle; it SHALL go to SHIFT if a synchronized ncs falling edge is detected in that cycle, otherwise to IDLE.
REQ-022 Latency: a written register SHALL be visible on its output 2 clk cycles after the cycle in which the synchronized ncs rising edge is detected.
REQ-023 If an sclk rising edge and an ncs rising edge are detected in the same cycle, ncs SHALL take priority and the sclk edge SHALL be ignored.
REQ-024 sclk edges while ncs is high SHALL be ignored, and frame_done and frame_err SHALL never assert together.
REQ-025 Correct capture SHALL be guaranteed only when the sclk high and low phases each last at least SYNC_STAGES+1 clk periods.

Reset
REQ-026 While rst is high, the block SHALL be in IDLE with all five configuration outputs at 8'h00, frame_done = 0, frame_err = 0, and the synchronizers, shift register, count and overrun cleared.
REQ-027 When rst asserts mid-frame, the block SHALL abort the frame with no register write and no pulse.
REQ-028 After rst deasserts mid-frame, the block SHALL wait for a fresh ncs falling edge before capturing.

Structure
REQ-029 A shared package SHALL hold the state enumeration, the frame field widths (1/7/8) and the register address constants (0x00 to 0x04).
REQ-030 The synchronizer plus edge detector SHALL be a single sub-module, spi_sync_edge, instantiated once per SPI input.

Verification
REQ-031 The bench SHALL send the frame 0x80F0 and check en_reg_out_7_0 = 0xF0, a single frame_done pulse, and all other registers still 0x00.
REQ-032 The bench SHALL send 0x8480 and check pwm_duty_cycle = 0x80 exactly 2 cycles after the synchronized ncs rise.
REQ-033 The bench SHALL send 0xB0AA (address 0x30) and 0x0055 (read), and check frame_done pulses with no register change and no frame_err.
REQ-034 The bench SHALL send a 15-bit frame and a 17-bit frame, each with write data 0xFF to address 0x01, and check that frame_err pulses and en_reg_out_15_8 stays 0x00.
REQ-035 The bench SHALL assert rst after 8 bits of 0x83FF, deassert it, then send 0x8301, and check en_reg_pwm_15_8 = 0x01 with no earlier write to it.
REQ-036 The bench SHALL send back-to-back frames 0x8211 and 0x8222, with ncs high for SYNC_STAGES+1 cycles between them, and check that en_reg_pwm_7_0 ends at 0x22 with two frame_done pulses.
